mp_regfile: RTL

MP_REGFILE -- requirements
Module: mp_regfile

---
 rtl/mp_regfile_pkg.sv | 14 +
 rtl/mp_regfile_rdport.sv | 47 ++++
 rtl/mp_regfile.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mp_regfile_pkg.sv
// Shared constants for the dual-write, multi-read register file.
package mp_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;
  localparam int NWR        = 2;

  // True when addr names a real register rather than the hardwired zero.
  function automatic logic is_real_reg(input logic [DEF_ADDR_W-1:0] addr);
    return addr != DEF_ADDR_W'(ZERO_REG);
  endfunction

endpackage

// File: rtl/mp_regfile_rdport.sv
// One read port: stored value and pending bit, with same-cycle write/issue bypass.
module mp_regfile_rdport
  import mp_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]     ra,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   wa,
  input  logic [2*DATA_W-1:0]   wd,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_a,
  input  logic [DATA_W-1:0]     stored_data,
  input  logic                  stored_pend,
  output logic [DATA_W-1:0]     rd,
  output logic                  rpend
);

  logic hit0, hit1, iss_hit, is_zero;

  always_comb begin
    is_zero = (ra == ADDR_W'(ZERO_REG));
    hit0    = we[0] && (wa[ADDR_W-1:0] == ra) && !is_zero;
    hit1    = we[1] && (wa[2*ADDR_W-1:ADDR_W] == ra) && !is_zero;
    iss_hit = iss_en && (iss_a == ra) && !is_zero;
  end

  // The younger write port wins when both target the read address.
  always_comb begin
    rd    = stored_data;
    rpend = stored_pend;
    if (hit1) begin
      rd = wd[2*DATA_W-1:DATA_W];
    end else if (hit0) begin
      rd = wd[DATA_W-1:0];
    end
    if ((hit0 || hit1) && !iss_hit) begin
      rpend = 1'b0;
    end
    if (is_zero) begin
      rd    = '0;
      rpend = 1'b0;
    end
  end

endmodule

// File: rtl/mp_regfile.sv
// Register file with two write ports, NRD read ports, pending scoreboard and commit trace.
module mp_regfile
  import mp_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              we,
  input  logic [2*ADDR_W-1:0]     wa,
  input  logic [2*DATA_W-1:0]     wd,
  input  logic [2*32-1:0]         wpc,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*DATA_W-1:0]   rd,
  output logic [NRD-1:0]          rpend,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_a,
  output logic [1:0]              trc_v,
  output logic [2*32-1:0]         trc_pc,
  output logic [2*ADDR_W-1:0]     trc_a,
  output logic [2*DATA_W-1:0]     trc_d
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [1:0]          trc_v_q, trc_v_d;
  logic [2*32-1:0]     trc_pc_q, trc_pc_d;
  logic [2*ADDR_W-1:0] trc_a_q, trc_a_d;
  logic [2*DATA_W-1:0] trc_d_q, trc_d_d;

  logic [ADDR_W-1:0] wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              commit0, commit1;

  // A port-0 write shadowed by port 1 to the same register is dropped entirely.
  always_comb begin
    wa0     = wa[ADDR_W-1:0];
    wa1     = wa[2*ADDR_W-1:ADDR_W];
    wd0     = wd[DATA_W-1:0];
    wd1     = wd[2*DATA_W-1:DATA_W];
    commit1 = we[1] && (wa1 != ADDR_W'(ZERO_REG));
    commit0 = we[0] && (wa0 != ADDR_W'(ZERO_REG)) && !(commit1 && (wa1 == wa0));
  end

  always_comb begin
    mem_d = mem_q;
    if (commit0) mem_d[wa0] = wd0;
    if (commit1) mem_d[wa1] = wd1;
  end

  // Write clears a pending bit, but a same-cycle issue to that register re-arms it.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < DEPTH; r++) begin
      if ((we[0] && (wa0 == ADDR_W'(r))) || (we[1] && (wa1 == ADDR_W'(r)))) begin
        pend_d[r] = 1'b0;
      end
      if (iss_en && (iss_a == ADDR_W'(r))) begin
        pend_d[r] = 1'b1;
      end
    end
    pend_d[ZERO_REG] = 1'b0;
  end

  always_comb begin
    trc_v_d  = {commit1, commit0};
    trc_pc_d = wpc;
    trc_a_d  = wa;
    trc_d_d  = wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      pend_q   <= '0;
      trc_v_q  <= '0;
      trc_pc_q <= '0;
      trc_a_q  <= '0;
      trc_d_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      pend_q   <= pend_d;
      trc_v_q  <= trc_v_d;
      trc_pc_q <= trc_pc_d;
      trc_a_q  <= trc_a_d;
      trc_d_q  <= trc_d_d;
    end
  end

  assign trc_v  = trc_v_q;
  assign trc_pc = trc_pc_q;
  assign trc_a  = trc_a_q;
  assign trc_d  = trc_d_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;
    assign ra_i = ra[i*ADDR_W +: ADDR_W];

    mp_regfile_rdport #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_rdport (
      .ra          (ra_i),
      .we          (we),
      .wa          (wa),
      .wd          (wd),
      .iss_en      (iss_en),
      .iss_a       (iss_a),
      .stored_data (mem_q[ra_i]),
      .stored_pend (pend_q[ra_i]),
      .rd          (rd[i*DATA_W +: DATA_W]),
      .rpend       (rpend[i])
    );
  end

endmodule
